load_store_unit: RTL and testbench

Initiator for the single-port data memory. Accepts one load or store request at a time from the execute stage and converts RV32I byte addresses into word-indexed `MemRead`/`MemWrite` cycles. Stores narrower than a word (SB, SH) are done as read-modify-write. Loads are byte-lane extracted and sign- or zero-extended. Sits between the ALU result/rs2 path and the data memory, and returns load data to writeback.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM state type and the latched request payload.
package lsu_pkg;

  localparam int unsigned LSU_WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_t;

  // Fields the datapath still needs after the request handshake.
  typedef struct packed {
    logic [2:0]            funct3;
    logic [1:0]            offset;
    logic [LSU_WORD_W-1:0] store_data;
  } lsu_req_t;

  // Stores only have byte/half/word widths; loads add the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the execute stage (master) and the
// load/store unit (slave).
interface lsu_if;
  import lsu_pkg::*;

  logic                  reqValid;
  logic                  reqReady;
  logic                  reqStore;
  logic [2:0]            reqFunct3;
  logic [LSU_WORD_W-1:0] reqAddress;
  logic [LSU_WORD_W-1:0] reqStoreData;
  logic                  respValid;
  logic [LSU_WORD_W-1:0] respLoadData;
  logic                  respFault;

  modport master (
    output reqValid, reqStore, reqFunct3, reqAddress, reqStoreData,
    input  reqReady, respValid, respLoadData, respFault
  );

  modport slave (
    input  reqValid, reqStore, reqFunct3, reqAddress, reqStoreData,
    output reqReady, respValid, respLoadData, respFault
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data, and merges
// narrow store data into the previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [LSU_WORD_W-1:0] word,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  input  logic [LSU_WORD_W-1:0] store_data,
  output logic [LSU_WORD_W-1:0] load_data_c,
  output logic [LSU_WORD_W-1:0] merged_c
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    byte_shift  = {offset, 3'b000};
    half_shift  = {offset[1], 4'b0000};
    lane_b      = 8'(word >> byte_shift);
    lane_h      = 16'(word >> half_shift);
    load_data_c = '0;
    merged_c    = word;
    case (funct3)
      F3_B: begin
        load_data_c = {{(LSU_WORD_W-8){lane_b[7]}}, lane_b};
        merged_c    = (word & ~(LSU_WORD_W'(8'hFF) << byte_shift))
                    | (LSU_WORD_W'(store_data[7:0]) << byte_shift);
      end
      F3_H: begin
        load_data_c = {{(LSU_WORD_W-16){lane_h[15]}}, lane_h};
        merged_c    = (word & ~(LSU_WORD_W'(16'hFFFF) << half_shift))
                    | (LSU_WORD_W'(store_data[15:0]) << half_shift);
      end
      F3_W: begin
        load_data_c = word;
        merged_c    = store_data;
      end
      F3_BU:   load_data_c = LSU_WORD_W'(lane_b);
      F3_HU:   load_data_c = LSU_WORD_W'(lane_h);
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one RV32I load/store at a time, narrow stores as
// read-modify-write. LSU_MISALIGN_TRAP_EN: fault on misaligned H/W accesses
// instead of forcing natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic                  clock,
  input  logic                  resetN,
  lsu_if.slave                  bus,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [LSU_WORD_W-1:0] address,
  output logic [LSU_WORD_W-1:0] writeData,
  input  logic [LSU_WORD_W-1:0] readData
);

  localparam int unsigned ADDR_LIMIT = 4 * MEM_WORDS;

  lsu_state_t            state;
  lsu_req_t              req;
  logic [LSU_WORD_W-1:0] eff_addr_c;
  logic                  fault_c;
  logic [LSU_WORD_W-1:0] load_data_c;
  logic [LSU_WORD_W-1:0] merged_c;

  // Request qualification, evaluated on the incoming (unlatched) request.
  always_comb begin
    eff_addr_c = bus.reqAddress;
    fault_c    = !f3_legal(bus.reqStore, bus.reqFunct3)
               || (bus.reqAddress >= LSU_WORD_W'(ADDR_LIMIT));
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.reqFunct3[1:0])
      2'b01:   fault_c = fault_c || bus.reqAddress[0];
      2'b10:   fault_c = fault_c || (bus.reqAddress[1:0] != 2'b00);
      default: ;
    endcase
`else
    case (bus.reqFunct3[1:0])
      2'b01:   eff_addr_c[0]   = 1'b0;
      2'b10:   eff_addr_c[1:0] = 2'b00;
      default: ;
    endcase
`endif
  end

  lsu_lane_align u_lane_align (
    .word        (readData),
    .offset      (req.offset),
    .funct3      (req.funct3),
    .store_data  (req.store_data),
    .load_data_c (load_data_c),
    .merged_c    (merged_c)
  );

  // Sequencer; every output is set on the edge that enters the state using it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      req              <= '0;
      bus.reqReady     <= 1'b1;
      bus.respValid    <= 1'b0;
      bus.respLoadData <= '0;
      bus.respFault    <= 1'b0;
      MemRead          <= 1'b0;
      MemWrite         <= 1'b0;
      address          <= '0;
      writeData        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid) begin
            bus.reqReady <= 1'b0;
            req <= '{funct3: bus.reqFunct3, offset: eff_addr_c[1:0],
                     store_data: bus.reqStoreData};
            if (fault_c) begin
              state            <= RESP;
              bus.respValid    <= 1'b1;
              bus.respFault    <= 1'b1;
              bus.respLoadData <= '0;
            end else begin
              address <= {2'b00, eff_addr_c[LSU_WORD_W-1:2]};
              if (!bus.reqStore) begin
                state   <= READ;
                MemRead <= 1'b1;
              end else if (bus.reqFunct3 == F3_W) begin
                state     <= WRITE;
                MemWrite  <= 1'b1;
                writeData <= bus.reqStoreData;
              end else begin
                state   <= RMW_READ;
                MemRead <= 1'b1;
              end
            end
          end
        end
        READ: begin
          state            <= RESP;
          MemRead          <= 1'b0;
          address          <= '0;
          bus.respValid    <= 1'b1;
          bus.respFault    <= 1'b0;
          bus.respLoadData <= load_data_c;
        end
        RMW_READ: begin
          state     <= WRITE;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b1;
          writeData <= merged_c;
        end
        WRITE: begin
          state            <= RESP;
          MemWrite         <= 1'b0;
          address          <= '0;
          writeData        <= '0;
          bus.respValid    <= 1'b1;
          bus.respFault    <= 1'b0;
          bus.respLoadData <= '0;
        end
        RESP: begin
          state            <= IDLE;
          bus.respValid    <= 1'b0;
          bus.respFault    <= 1'b0;
          bus.respLoadData <= '0;
          bus.reqReady     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-addressed reference memory
// predicts every response; a monitor checks responses and bus behaviour.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 32;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  logic        clock = 1'b0;
  logic        resetN;
  logic        MemRead, MemWrite;
  logic [31:0] address, writeData, readData;
  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  refb [MEM_BYTES];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit          st;
    logic        fault;
    logic [31:0] data;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  lsu_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .bus       (bus),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .address   (address),
    .writeData (writeData),
    .readData  (readData)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory behind the unit: combinational read, write on the strobe edge.
  assign readData = mem[address[4:0]];
  always @(posedge clock) if (MemWrite) mem[address[4:0]] <= writeData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: little-endian byte memory, rules taken straight from the ISA view.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a_in,
                       input logic [31:0] sd, output exp_t e);
    int          size;
    int          a;
    bit          legal;
    bit          mis;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = 1'b0;
    a     = int'(a_in % 32'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (a % size) != 0;
`else
    a = a - (a % size);
`endif
    e = '{st: st, fault: 1'b0, data: 32'h0, lat: 0, nrd: 0, nwr: 0,
          waddr: 32'h0, wdata: 32'h0, acc: 0};
    if (!legal || a_in >= 32'(MEM_BYTES) || mis) begin
      e.fault = 1'b1;
      e.lat   = 1;
    end else if (!st) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(refb[a + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      e.data  = v;
      e.lat   = 2;
      e.nrd   = 1;
      e.waddr = 32'(a / 4);
    end else begin
      for (int i = 0; i < size; i++) refb[a + i] = 8'(sd >> (8 * i));
      e.lat   = (size == 4) ? 2 : 3;
      e.nrd   = (size == 4) ? 0 : 1;
      e.nwr   = 1;
      e.waddr = 32'(a / 4);
      e.wdata = {refb[(a / 4) * 4 + 3], refb[(a / 4) * 4 + 2],
                 refb[(a / 4) * 4 + 1], refb[(a / 4) * 4]};
    end
  endtask

  task automatic junk();
    bus.reqValid     = 1'($urandom_range(0, 1));
    bus.reqStore     = 1'($urandom_range(0, 1));
    bus.reqFunct3    = 3'($urandom_range(0, 7));
    bus.reqAddress   = 32'($urandom_range(0, MEM_BYTES - 1));
    bus.reqStoreData = $urandom;
  endtask

  // Waits (bounded) at negedges until the unit is ready, driving ignored junk meanwhile.
  task automatic wait_ready();
    int guard = 0;
    while (!bus.reqReady) begin
      junk();
      @(negedge clock);
      guard++;
      if (guard > 50) begin
        $display("FAIL ready_timeout actual=busy required=ready");
        $fatal(1, "reqReady never returned");
      end
    end
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    exp_t e;
    wait_ready();
    bus.reqValid     = 1'b1;
    bus.reqStore     = st;
    bus.reqFunct3    = f3;
    bus.reqAddress   = a;
    bus.reqStoreData = sd;
    model(st, f3, a, sd, e);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    junk();
  endtask

  // Monitor: strobe hygiene every cycle, scoreboard compare on each response.
  initial begin
    int          nrd = 0;
    int          nwr = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wd = 32'h0;
    bit          after_resp = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        chk("rst_ready", 32'(bus.reqReady), 32'd1);
        chk("rst_resp", {29'd0, bus.respValid, bus.respFault, |bus.respLoadData}, 32'd0);
        chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rst_bus", address | writeData, 32'd0);
        nrd = 0;
        nwr = 0;
        after_resp = 1'b0;
      end else begin
        chk("strobe_excl", 32'(MemRead && MemWrite), 32'd0);
        if (!MemRead && !MemWrite) chk("idle_bus", address | writeData, 32'd0);
        if (MemRead) begin nrd++; last_addr = address; end
        if (MemWrite) begin nwr++; last_addr = address; last_wd = writeData; end
        if (after_resp) begin
          chk("ready_after_resp", {30'd0, bus.reqReady, bus.respValid}, 32'd2);
          after_resp = 1'b0;
        end
        if (bus.respValid) begin
          chk("ready_in_resp", 32'(bus.reqReady), 32'd0);
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("fault", 32'(bus.respFault), 32'(e.fault));
            if (!e.st) chk("load_data", bus.respLoadData, e.data);
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("n_read", 32'(nrd), 32'(e.nrd));
            chk("n_write", 32'(nwr), 32'(e.nwr));
            if (e.nrd + e.nwr > 0) chk("strobe_addr", last_addr, e.waddr);
            if (e.nwr > 0) chk("write_data", last_wd, e.wdata);
          end
          nrd = 0;
          nwr = 0;
          after_resp = 1'b1;
        end
      end
    end
  end

  initial begin
    int guard;
    bus.reqValid     = 1'b0;
    bus.reqStore     = 1'b0;
    bus.reqFunct3    = 3'd0;
    bus.reqAddress   = 32'd0;
    bus.reqStoreData = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) refb[i] = 8'h00;
    resetN = 1'b0;
    repeat (3) @(negedge clock);
    #1 resetN = 1'b1;
    @(negedge clock);

    for (int w = 0; w < MEM_WORDS; w++) issue(1'b1, F3_W, 32'(4 * w), $urandom);

    issue(1'b1, F3_W,  32'h08, 32'hDEADBEEF);
    issue(1'b0, F3_W,  32'h08, 32'h0);
    issue(1'b0, F3_B,  32'h0B, 32'h0);
    issue(1'b0, F3_BU, 32'h0B, 32'h0);
    issue(1'b0, F3_HU, 32'h08, 32'h0);
    issue(1'b0, F3_H,  32'h0A, 32'h0);
    issue(1'b1, F3_W,  32'h08, 32'h11223344);
    issue(1'b1, F3_B,  32'h09, 32'h00000055);
    issue(1'b0, F3_W,  32'h08, 32'h0);
    issue(1'b0, F3_W,  32'h06, 32'h0);
    issue(1'b1, F3_H,  32'h0F, 32'hCAFE1234);
    issue(1'b1, F3_W,  32'h80, 32'h12345678);
    issue(1'b0, 3'b011, 32'h00, 32'h0);
    issue(1'b1, F3_BU, 32'h04, 32'hFF);
    issue(1'b0, F3_W,  32'h7C, 32'h0);
    issue(1'b0, F3_B,  32'h7F, 32'h0);
    issue(1'b0, F3_B,  32'h80, 32'h0);

    // Reset while an SH sits in RMW_READ: the aborted store must not land.
    wait_ready();
    bus.reqValid     = 1'b1;
    bus.reqStore     = 1'b1;
    bus.reqFunct3    = F3_H;
    bus.reqAddress   = 32'h10;
    bus.reqStoreData = 32'h0000A5A5;
    @(posedge clock);
    @(negedge clock);
    #1 resetN = 1'b0;
    bus.reqValid = 1'b0;
    @(negedge clock);
    #1 resetN = 1'b1;
    @(negedge clock);
    issue(1'b0, F3_W, 32'h10, 32'h0);

    repeat (300) begin
      logic [2:0]  f3;
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      if ($urandom_range(0, 9) == 0) a = 32'(MEM_BYTES) + 32'($urandom_range(0, 4000));
      else a = 32'($urandom_range(0, MEM_BYTES - 1));
      issue(1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    for (int w = 0; w < MEM_WORDS; w++) issue(1'b0, F3_W, 32'(4 * w), 32'h0);

    bus.reqValid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 || !bus.reqReady) begin
      @(negedge clock);
      guard++;
      if (guard > 50) begin
        $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
        $fatal(1, "responses outstanding");
      end
    end
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
